// File: rtl/digest_serializer_if.sv
// ============================================================================
// digest_serializer_if
// Output beat bus (valid/ready plus last/keep qualifiers) of digest_serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface digest_serializer_if #(
    parameter int BUS_WIDTH = 64
);
    logic [BUS_WIDTH-1:0]   dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dout_last;
    logic [BUS_WIDTH/8-1:0] dout_keep;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        output dout_keep,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        input  dout_keep,
        output dout_ready
    );
endinterface

`default_nettype wire

// File: rtl/digest_serializer.sv
// ============================================================================
// digest_serializer
// Captures a digest on a rising digest_valid and streams it MSB-first as beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module digest_serializer #(
    parameter int BUS_WIDTH    = 64,
    parameter int DIGEST_WIDTH = 512
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic                    digest_valid,
    input  wire logic [DIGEST_WIDTH-1:0] digest,
    input  wire logic                    abort,
    digest_serializer_if.master          bus,
    output logic                         busy,
    output logic                         overrun
);
    localparam int KEEP_W  = BUS_WIDTH / 8;
    localparam int BEATS   = (DIGEST_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int TOTAL_W = BEATS * BUS_WIDTH;
    localparam int PAD_W   = TOTAL_W - DIGEST_WIDTH;
    localparam int REM_B   = (DIGEST_WIDTH % BUS_WIDTH) / 8;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]  C_LAST_CNT  = CNT_W'(BEATS - 1);
    // Partial last beat keeps only the top REM_B byte lanes.
    localparam logic [KEEP_W-1:0] C_LAST_KEEP =
        (REM_B == 0) ? {KEEP_W{1'b1}} : ~({KEEP_W{1'b1}} >> REM_B);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TOTAL_W-1:0] r_shift;
    logic               r_dv_q;
    logic               r_overrun;

    logic               w_rise;
    logic               w_send;
    logic               w_last;
    logic               w_xfer;
    logic               w_last_xfer;
    logic [TOTAL_W-1:0] w_load;

    assign w_rise      = digest_valid & ~r_dv_q;
    assign w_send      = (r_state == ST_SEND);
    assign w_last      = w_send && (r_cnt == C_LAST_CNT);
    assign w_xfer      = w_send & bus.dout_ready;
    assign w_last_xfer = w_xfer & w_last;
    assign w_load      = TOTAL_W'(digest) << PAD_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_dv_q    <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_dv_q    <= digest_valid;
            r_overrun <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= ST_SEND;
                            r_cnt   <= '0;
                            r_shift <= w_load;
                        end
                    end
                    ST_SEND: begin
                        if (w_last_xfer) begin
                            r_cnt <= '0;
                            // A new digest landing on the final handshake reloads with no bubble.
                            if (w_rise) begin
                                r_shift <= w_load;
                            end else begin
                                r_state <= ST_IDLE;
                                r_shift <= r_shift << BUS_WIDTH;
                            end
                        end else begin
                            r_overrun <= w_rise;
                            if (w_xfer) begin
                                r_shift <= r_shift << BUS_WIDTH;
                                r_cnt   <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = r_shift[TOTAL_W-1 -: BUS_WIDTH];
    assign bus.dout_valid = w_send;
    assign bus.dout_last  = w_last;
    assign bus.dout_keep  = !w_send ? '0 : (w_last ? C_LAST_KEEP : {KEEP_W{1'b1}});
    assign busy           = w_send;
    assign overrun        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_digest_serializer.sv
// ============================================================================
// tb_digest_serializer
// Directed bench for an 88-bit and a 512-bit instance of digest_serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_digest_serializer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         dv88, ab88, busy88, ovr88;
    logic [87:0]  dg88;
    logic         dv512, ab512, busy512, ovr512;
    logic [511:0] dg512;

    digest_serializer_if #(.BUS_WIDTH(64)) b88 ();
    digest_serializer_if #(.BUS_WIDTH(64)) b512 ();

    digest_serializer #(.BUS_WIDTH(64), .DIGEST_WIDTH(88)) u88 (
        .clk(clk), .reset_n(reset_n), .digest_valid(dv88), .digest(dg88),
        .abort(ab88), .bus(b88.master), .busy(busy88), .overrun(ovr88)
    );

    digest_serializer #(.BUS_WIDTH(64), .DIGEST_WIDTH(512)) u512 (
        .clk(clk), .reset_n(reset_n), .digest_valid(dv512), .digest(dg512),
        .abort(ab512), .bus(b512.master), .busy(busy512), .overrun(ovr512)
    );

    localparam logic [87:0]  C_X88 = 88'h0102030405060708090A0B;
    localparam logic [87:0]  C_Y88 = 88'hF1F2F3F4F5F6F7F8F9FAFB;
    localparam logic [511:0] C_A512 = {
        64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444,
        64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};
    localparam logic [511:0] C_B512 = {8{64'hFEDCBA9876543210}};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word512(input int k);
        logic [7:0] b;
        b = 8'(8'h11 * (k + 1));
        return {8{b}};
    endfunction

    task automatic beat88(input string tag, input logic [63:0] d, input logic [7:0] k, input logic l);
        chk({tag, "_valid"}, 64'(b88.dout_valid), 64'd1);
        chk({tag, "_dout"},  b88.dout, d);
        chk({tag, "_keep"},  64'(b88.dout_keep), 64'(k));
        chk({tag, "_last"},  64'(b88.dout_last), 64'(l));
    endtask

    task automatic beat512(input string tag, input int k);
        chk({tag, "_valid"}, 64'(b512.dout_valid), 64'd1);
        chk({tag, "_dout"},  b512.dout, word512(k));
        chk({tag, "_keep"},  64'(b512.dout_keep), 64'hFF);
        chk({tag, "_last"},  64'(b512.dout_last), (k == 7) ? 64'd1 : 64'd0);
    endtask

    // Expects beat 0 presented now and dout_ready already high.
    task automatic drain512(input string tag);
        for (int k = 0; k < 8; k++) begin
            beat512(tag, k);
            tick();
        end
        chk({tag, "_end_valid"}, 64'(b512.dout_valid), 64'd0);
        chk({tag, "_end_busy"},  64'(busy512), 64'd0);
    endtask

    task automatic idle_all(input string tag);
        chk({tag, "_d88"},    b88.dout, 64'd0);
        chk({tag, "_v88"},    64'(b88.dout_valid), 64'd0);
        chk({tag, "_l88"},    64'(b88.dout_last), 64'd0);
        chk({tag, "_k88"},    64'(b88.dout_keep), 64'd0);
        chk({tag, "_b88"},    64'(busy88), 64'd0);
        chk({tag, "_o88"},    64'(ovr88), 64'd0);
        chk({tag, "_d512"},   b512.dout, 64'd0);
        chk({tag, "_v512"},   64'(b512.dout_valid), 64'd0);
        chk({tag, "_k512"},   64'(b512.dout_keep), 64'd0);
        chk({tag, "_b512"},   64'(busy512), 64'd0);
    endtask

    initial begin
        int beat;
        logic rdy;

        reset_n = 1'b0;
        dv88 = 1'b0; ab88 = 1'b0; dg88 = '0;
        dv512 = 1'b0; ab512 = 1'b0; dg512 = '0;
        b88.dout_ready = 1'b0;
        b512.dout_ready = 1'b0;
        tick();
        tick();
        idle_all("reset");
        reset_n = 1'b1;
        tick();

        // 88-bit digest, ready held high
        dg88 = C_X88; dv88 = 1'b1; b88.dout_ready = 1'b1;
        tick();
        dv88 = 1'b0;
        beat88("t88_b0", 64'h0102030405060708, 8'hFF, 1'b0);
        chk("t88_busy", 64'(busy88), 64'd1);
        tick();
        beat88("t88_b1", 64'h090A0B0000000000, 8'hE0, 1'b1);
        tick();
        chk("t88_done_valid", 64'(b88.dout_valid), 64'd0);
        chk("t88_done_busy",  64'(busy88), 64'd0);
        chk("t88_done_last",  64'(b88.dout_last), 64'd0);

        // 512-bit digest, ready pattern 1,0,0 repeating
        dg512 = C_A512; dv512 = 1'b1;
        tick();
        dv512 = 1'b0;
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            beat512("t512", beat);
            rdy = (c % 3 == 0);
            b512.dout_ready = rdy;
            tick();
            if (rdy) beat++;
        end
        chk("t512_beats", 64'(beat), 64'd8);
        chk("t512_end_valid", 64'(b512.dout_valid), 64'd0);
        chk("t512_end_busy",  64'(busy512), 64'd0);

        // Second rise while beat 0 is stalled
        b512.dout_ready = 1'b0;
        dg512 = C_A512; dv512 = 1'b1;
        tick();
        dv512 = 1'b0;
        beat512("ovr_stall", 0);
        tick();
        dg512 = C_B512; dv512 = 1'b1;
        tick();
        dv512 = 1'b0;
        chk("ovr_pulse", 64'(ovr512), 64'd1);
        beat512("ovr_hold", 0);
        tick();
        chk("ovr_clear", 64'(ovr512), 64'd0);
        b512.dout_ready = 1'b1;
        drain512("ovr_drain");
        chk("ovr_after", 64'(ovr512), 64'd0);

        // Back-to-back reload on the last-beat transfer
        dg88 = C_X88; dv88 = 1'b1;
        tick();
        dv88 = 1'b0;
        beat88("b2b_x0", 64'h0102030405060708, 8'hFF, 1'b0);
        tick();
        beat88("b2b_x1", 64'h090A0B0000000000, 8'hE0, 1'b1);
        dg88 = C_Y88; dv88 = 1'b1;
        tick();
        dv88 = 1'b0;
        chk("b2b_busy", 64'(busy88), 64'd1);
        chk("b2b_ovr",  64'(ovr88), 64'd0);
        beat88("b2b_y0", 64'hF1F2F3F4F5F6F7F8, 8'hFF, 1'b0);
        tick();
        beat88("b2b_y1", 64'hF9FAFB0000000000, 8'hE0, 1'b1);
        tick();
        chk("b2b_end_valid", 64'(b88.dout_valid), 64'd0);

        // Abort on beat 3, with a coincident rise that must be dropped silently
        dg512 = C_A512; dv512 = 1'b1;
        tick();
        dv512 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat512("abt_pre", k);
            tick();
        end
        beat512("abt_b3", 3);
        ab512 = 1'b1; dv512 = 1'b1; dg512 = C_B512;
        tick();
        ab512 = 1'b0; dv512 = 1'b0;
        chk("abt_valid", 64'(b512.dout_valid), 64'd0);
        chk("abt_last",  64'(b512.dout_last), 64'd0);
        chk("abt_busy",  64'(busy512), 64'd0);
        chk("abt_ovr",   64'(ovr512), 64'd0);
        tick();
        chk("abt_stay_idle", 64'(b512.dout_valid), 64'd0);
        dg512 = C_A512; dv512 = 1'b1;
        tick();
        dv512 = 1'b0;
        drain512("abt_retry");

        // Reset mid-transfer with digest_valid held through release
        b88.dout_ready = 1'b0;
        dg88 = C_X88; dv88 = 1'b1;
        tick();
        beat88("rst_pre", 64'h0102030405060708, 8'hFF, 1'b0);
        #2 reset_n = 1'b0;
        #1 idle_all("rst_async");
        tick();
        reset_n = 1'b1;
        b88.dout_ready = 1'b1;
        tick();
        tick();
        chk("rst_nocap_valid", 64'(b88.dout_valid), 64'd0);
        chk("rst_nocap_busy",  64'(busy88), 64'd0);
        dv88 = 1'b0;
        tick();
        chk("rst_fall_valid", 64'(b88.dout_valid), 64'd0);
        dg88 = C_Y88; dv88 = 1'b1;
        tick();
        dv88 = 1'b0;
        beat88("rst_recap0", 64'hF1F2F3F4F5F6F7F8, 8'hFF, 1'b0);
        tick();
        beat88("rst_recap1", 64'hF9FAFB0000000000, 8'hE0, 1'b1);
        tick();
        chk("rst_recap_end", 64'(b88.dout_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
